video_timing_gen: RTL and testbench

Raster timing generator for the HDMI output path, clocked by `video_clk` and reset by the `reset` output of the clock/reset block. It produces pixel coordinates, a per-line fetch request for the frame-buffer reader, and HSYNC/VSYNC/DE delayed to match the pixel pipeline feeding the TMDS encoders. Defaults are 1280x720p60 at 74.25 MHz.

---
 rtl/video_timing_gen.sv | 141 ++++++++++++++
 tb/tb_video_timing_gen.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator: stage-0 pixel coordinates and line-fetch requests,
// plus HSYNC/VSYNC/DE delayed to line up with the downstream pixel pipeline.
module video_timing_gen #(
  parameter int   H_VISIBLE = 1280,
  parameter int   H_FRONT   = 110,
  parameter int   H_SYNC    = 40,
  parameter int   H_BACK    = 220,
  parameter int   V_VISIBLE = 720,
  parameter int   V_FRONT   = 5,
  parameter int   V_SYNC    = 5,
  parameter int   V_BACK    = 20,
  parameter logic H_POL     = 1'b1,
  parameter logic V_POL     = 1'b1,
  parameter int   PIPE_DLY  = 2
) (
  input  logic        video_clk,
  input  logic        reset,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        active,
  output logic        frame_start,
  output logic        line_req,
  output logic [11:0] line_num,
  output logic        hsync,
  output logic        vsync,
  output logic        de
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [12:0] H_VIS_W   = 13'(H_VISIBLE);
  localparam logic [12:0] V_VIS_W   = 13'(V_VISIBLE);
  localparam logic [12:0] HS_BEGIN  = 13'(H_VISIBLE + H_FRONT);
  localparam logic [12:0] HS_END    = 13'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [12:0] VS_BEGIN  = 13'(V_VISIBLE + V_FRONT);
  localparam logic [12:0] VS_END    = 13'(V_VISIBLE + V_FRONT + V_SYNC);

  logic        run_q;
  logic [11:0] x_q, y_q, x_d, y_d;
  logic        active_q, active_d;
  logic        frame_start_q, frame_start_d;
  logic        line_req_q, line_req_d;
  logic [11:0] line_num_q, line_num_d;
  logic        hs_raw_q, hs_raw_d;
  logic        vs_raw_q, vs_raw_d;
  logic [11:0] nl_s;
  logic        hs_out_s, vs_out_s, de_out_s;

  // Next stage-0 position and every flag derived from it, so all stage-0 outputs are registered.
  always_comb begin
    x_d = 12'd0;
    y_d = 12'd0;
    if (run_q) begin
      if (x_q == H_LAST) begin
        x_d = 12'd0;
        y_d = (y_q == V_LAST) ? 12'd0 : (y_q + 12'd1);
      end else begin
        x_d = x_q + 12'd1;
        y_d = y_q;
      end
    end else begin
      x_d = 12'd0;
      y_d = 12'd0;
    end

    nl_s          = (y_d == V_LAST) ? 12'd0 : (y_d + 12'd1);
    active_d      = ({1'b0, x_d} < H_VIS_W) && ({1'b0, y_d} < V_VIS_W);
    frame_start_d = (x_d == 12'd0) && (y_d == 12'd0);
    line_req_d    = ({1'b0, x_d} == H_VIS_W) && ({1'b0, nl_s} < V_VIS_W);
    line_num_d    = line_req_d ? nl_s : line_num_q;
    hs_raw_d      = ({1'b0, x_d} >= HS_BEGIN) && ({1'b0, x_d} < HS_END);
    vs_raw_d      = ({1'b0, y_d} >= VS_BEGIN) && ({1'b0, y_d} < VS_END);
  end

  // Stage-0 state; run_q holds the first post-reset edge at (0,0) before counting starts.
  always_ff @(posedge video_clk) begin
    if (reset) begin
      run_q         <= 1'b0;
      x_q           <= 12'd0;
      y_q           <= 12'd0;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
      line_req_q    <= 1'b0;
      line_num_q    <= 12'd0;
      hs_raw_q      <= 1'b0;
      vs_raw_q      <= 1'b0;
    end else begin
      run_q         <= 1'b1;
      x_q           <= x_d;
      y_q           <= y_d;
      active_q      <= active_d;
      frame_start_q <= frame_start_d;
      line_req_q    <= line_req_d;
      line_num_q    <= line_num_d;
      hs_raw_q      <= hs_raw_d;
      vs_raw_q      <= vs_raw_d;
    end
  end

  generate
    if (PIPE_DLY == 0) begin : g_no_dly
      assign hs_out_s = hs_raw_q;
      assign vs_out_s = vs_raw_q;
      assign de_out_s = active_q;
    end else begin : g_dly
      logic [2:0] dly_q [PIPE_DLY];

      // Shift {hsync, vsync, active}; reset flushes every stage to the inactive level.
      always_ff @(posedge video_clk) begin
        if (reset) begin
          for (int i = 0; i < PIPE_DLY; i++) begin
            dly_q[i] <= 3'b000;
          end
        end else begin
          dly_q[0] <= {hs_raw_q, vs_raw_q, active_q};
          for (int i = 1; i < PIPE_DLY; i++) begin
            dly_q[i] <= dly_q[i-1];
          end
        end
      end

      assign hs_out_s = dly_q[PIPE_DLY-1][2];
      assign vs_out_s = dly_q[PIPE_DLY-1][1];
      assign de_out_s = dly_q[PIPE_DLY-1][0];
    end
  endgenerate

  assign x           = x_q;
  assign y           = y_q;
  assign active      = active_q;
  assign frame_start = frame_start_q;
  assign line_req    = line_req_q;
  assign line_num    = line_num_q;
  assign hsync       = hs_out_s ? H_POL : ~H_POL;
  assign vsync       = vs_out_s ? V_POL : ~V_POL;
  assign de          = de_out_s;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: two small-raster instances checked every cycle
// against an arithmetic raster model (pixel index -> x, y, windows, delay).
module tb_video_timing_gen;

  localparam int A_HV = 16, A_HF = 3, A_HS = 4, A_HB = 5;
  localparam int A_VV = 6,  A_VF = 2, A_VS = 2, A_VB = 3;
  localparam int B_HV = 10, B_HF = 2, B_HS = 3, B_HB = 4;
  localparam int B_VV = 4,  B_VF = 1, B_VS = 2, B_VB = 2;

  typedef struct {
    int hv, hf, hs, hb, vv, vf, vs, vb;
    bit hp, vp;
    int d;
  } cfg_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [11:0] x_a, y_a, ln_a, x_b, y_b, ln_b;
  logic act_a, fs_a, lr_a, hs_a, vs_a, de_a;
  logic act_b, fs_b, lr_b, hs_b, vs_b, de_b;
  wire  [41:0] obs_a = {x_a, y_a, act_a, fs_a, lr_a, ln_a, hs_a, vs_a, de_a};
  wire  [41:0] obs_b = {x_b, y_b, act_b, fs_b, lr_b, ln_b, hs_b, vs_b, de_b};

  cfg_t cfg_a, cfg_b;
  int cnt = -1;
  logic [11:0] lm_a = 12'd0, lm_b = 12'd0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_VISIBLE(A_HV), .H_FRONT(A_HF), .H_SYNC(A_HS), .H_BACK(A_HB),
    .V_VISIBLE(A_VV), .V_FRONT(A_VF), .V_SYNC(A_VS), .V_BACK(A_VB),
    .H_POL(1'b1), .V_POL(1'b1), .PIPE_DLY(2)
  ) dut_a (
    .video_clk(clk), .reset(rst), .x(x_a), .y(y_a), .active(act_a),
    .frame_start(fs_a), .line_req(lr_a), .line_num(ln_a),
    .hsync(hs_a), .vsync(vs_a), .de(de_a)
  );

  video_timing_gen #(
    .H_VISIBLE(B_HV), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
    .V_VISIBLE(B_VV), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB),
    .H_POL(1'b0), .V_POL(1'b0), .PIPE_DLY(0)
  ) dut_b (
    .video_clk(clk), .reset(rst), .x(x_b), .y(y_b), .active(act_b),
    .frame_start(fs_b), .line_req(lr_b), .line_num(ln_b),
    .hsync(hs_b), .vsync(vs_b), .de(de_b)
  );

  function automatic int h_total(cfg_t c);
    return c.hv + c.hf + c.hs + c.hb;
  endfunction

  function automatic int v_total(cfg_t c);
    return c.vv + c.vf + c.vs + c.vb;
  endfunction

  function automatic int next_line(cfg_t c, int py);
    return (py == v_total(c) - 1) ? 0 : py + 1;
  endfunction

  // Expected outputs for the edge that is cnt pixels after reset release (cnt<0: in reset).
  function automatic logic [41:0] model_out(cfg_t c, int n, logic [11:0] lnum);
    int ht, vt, p, px, py, q, qx, qy;
    logic [11:0] xv, yv;
    logic act, fs, lr, hr, vr, dr;
    ht = h_total(c);
    vt = v_total(c);
    xv = 12'd0; yv = 12'd0;
    act = 1'b0; fs = 1'b0; lr = 1'b0; hr = 1'b0; vr = 1'b0; dr = 1'b0;
    if (n >= 0) begin
      p  = n % (ht * vt);
      px = p % ht;
      py = p / ht;
      xv = 12'(px);
      yv = 12'(py);
      act = (px < c.hv) && (py < c.vv);
      fs  = (p == 0);
      lr  = (px == c.hv) && (next_line(c, py) < c.vv);
    end
    if (n >= c.d) begin
      q  = (n - c.d) % (ht * vt);
      qx = q % ht;
      qy = q / ht;
      hr = (qx >= c.hv + c.hf) && (qx < c.hv + c.hf + c.hs);
      vr = (qy >= c.vv + c.vf) && (qy < c.vv + c.vf + c.vs);
      dr = (qx < c.hv) && (qy < c.vv);
    end
    return {xv, yv, act, fs, lr, lnum, (hr ? c.hp : ~c.hp), (vr ? c.vp : ~c.vp), dr};
  endfunction

  // Advance one clock, update the model, and return at the falling edge for sampling.
  task automatic tick();
    logic [41:0] t;
    @(posedge clk);
    if (rst) begin
      cnt  = -1;
      lm_a = 12'd0;
      lm_b = 12'd0;
    end else begin
      cnt++;
      t = model_out(cfg_a, cnt, lm_a);
      if (t[15]) lm_a = 12'(next_line(cfg_a, int'(t[29:18])));
      t = model_out(cfg_b, cnt, lm_b);
      if (t[15]) lm_b = 12'(next_line(cfg_b, int'(t[29:18])));
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [41:0] ea, eb;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      ea = model_out(cfg_a, cnt, lm_a);
      eb = model_out(cfg_b, cnt, lm_b);
      checks++;
      if (obs_a !== ea) begin errors++; $display("FAIL reset_a got=%h exp=%h", obs_a, ea); end
      checks++;
      if (obs_b !== eb) begin errors++; $display("FAIL reset_b got=%h exp=%h", obs_b, eb); end
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      ea = model_out(cfg_a, cnt, lm_a);
      checks++;
      if (obs_a !== ea) begin errors++; $display("FAIL release_a k=%0d got=%h exp=%h", k, obs_a, ea); end
      checks++;
      if (de_a !== (k == 2)) begin errors++; $display("FAIL de_latency k=%0d got=%b exp=%b", k, de_a, (k == 2)); end
      if (k == 0) begin
        checks++;
        if ({x_a, y_a, fs_a, act_a, hs_a, vs_a} !== {12'd0, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL edge_e x=%0d y=%0d fs=%b act=%b hs=%b vs=%b", x_a, y_a, fs_a, act_a, hs_a, vs_a);
        end
      end
    end
  endtask

  task automatic test_sweep();
    logic [41:0] ea, eb;
    int fa, ha, p;
    int n_lr = 0, n_de = 0, n_fs = 0, last_fs = -1;
    fa = h_total(cfg_a) * v_total(cfg_a);
    ha = h_total(cfg_a);
    for (int i = 0; i < 2 * fa + 10; i++) begin
      tick();
      ea = model_out(cfg_a, cnt, lm_a);
      eb = model_out(cfg_b, cnt, lm_b);
      checks++;
      if (obs_a !== ea) begin errors++; $display("FAIL sweep_a cnt=%0d got=%h exp=%h", cnt, obs_a, ea); end
      checks++;
      if (obs_b !== eb) begin errors++; $display("FAIL sweep_b cnt=%0d got=%h exp=%h", cnt, obs_b, eb); end
      p = cnt % fa;
      if (p == (v_total(cfg_a) - 1) * ha + cfg_a.hv) begin
        checks++;
        if ({lr_a, ln_a} !== {1'b1, 12'd0}) begin errors++; $display("FAIL line0_req lr=%b ln=%0d exp lr=1 ln=0", lr_a, ln_a); end
      end
      if (p == (cfg_a.vv - 1) * ha + cfg_a.hv) begin
        checks++;
        if (lr_a !== 1'b0) begin errors++; $display("FAIL last_vis_noreq lr=%b exp=0", lr_a); end
      end
      if (cnt >= fa && cnt < 2 * fa) begin
        if (lr_a === 1'b1) n_lr++;
        if (de_a === 1'b1) n_de++;
        if (fs_a === 1'b1) n_fs++;
      end
      if (fs_a === 1'b1) begin
        if (last_fs >= 0) begin
          checks++;
          if (cnt - last_fs != fa) begin errors++; $display("FAIL frame_period got=%0d exp=%0d", cnt - last_fs, fa); end
        end
        last_fs = cnt;
      end
    end
    checks++;
    if (n_lr != cfg_a.vv) begin errors++; $display("FAIL lr_count got=%0d exp=%0d", n_lr, cfg_a.vv); end
    checks++;
    if (n_de != cfg_a.hv * cfg_a.vv) begin errors++; $display("FAIL de_count got=%0d exp=%0d", n_de, cfg_a.hv * cfg_a.vv); end
    checks++;
    if (n_fs != 1) begin errors++; $display("FAIL fs_count got=%0d exp=1", n_fs); end
  endtask

  task automatic test_mid_reset();
    logic [41:0] ea, eb;
    int fa, target;
    fa = h_total(cfg_a) * v_total(cfg_a);
    target = 3 * h_total(cfg_a) + 10;
    for (int i = 0; i < fa && (cnt % fa) != target; i++) begin
      tick();
      ea = model_out(cfg_a, cnt, lm_a);
      checks++;
      if (obs_a !== ea) begin errors++; $display("FAIL seek_a cnt=%0d got=%h exp=%h", cnt, obs_a, ea); end
    end
    checks++;
    if ((cnt % fa) != target) begin errors++; $display("FAIL seek_timeout pos=%0d exp=%0d", cnt % fa, target); end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      ea = model_out(cfg_a, cnt, lm_a);
      eb = model_out(cfg_b, cnt, lm_b);
      checks++;
      if (obs_a !== ea) begin errors++; $display("FAIL midrst_a k=%0d got=%h exp=%h", k, obs_a, ea); end
      checks++;
      if (obs_b !== eb) begin errors++; $display("FAIL midrst_b k=%0d got=%h exp=%h", k, obs_b, eb); end
      if (k == 0) begin
        checks++;
        if ({hs_a, vs_a, de_a, act_a, lr_a, fs_a, hs_b, vs_b} !== 8'b0000_0011) begin
          errors++;
          $display("FAIL midrst_flush got=%b exp=00000011", {hs_a, vs_a, de_a, act_a, lr_a, fs_a, hs_b, vs_b});
        end
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({x_a, y_a, fs_a, x_b, y_b, fs_b} !== {12'd0, 12'd0, 1'b1, 12'd0, 12'd0, 1'b1}) begin
      errors++;
      $display("FAIL restart xa=%0d ya=%0d fsa=%b xb=%0d yb=%0d fsb=%b", x_a, y_a, fs_a, x_b, y_b, fs_b);
    end
  endtask

  task automatic test_polarity();
    logic [41:0] eb;
    int fb, n_hl = 0, n_vl = 0;
    fb = h_total(cfg_b) * v_total(cfg_b);
    for (int i = 0; i < fb; i++) begin
      tick();
      eb = model_out(cfg_b, cnt, lm_b);
      checks++;
      if (obs_b !== eb) begin errors++; $display("FAIL pol_b cnt=%0d got=%h exp=%h", cnt, obs_b, eb); end
      checks++;
      if (de_b !== act_b) begin errors++; $display("FAIL de_eq_active de=%b active=%b", de_b, act_b); end
      if (hs_b === 1'b0) n_hl++;
      if (vs_b === 1'b0) n_vl++;
    end
    checks++;
    if (n_hl != cfg_b.hs * v_total(cfg_b)) begin errors++; $display("FAIL hs_low_count got=%0d exp=%0d", n_hl, cfg_b.hs * v_total(cfg_b)); end
    checks++;
    if (n_vl != cfg_b.vs * h_total(cfg_b)) begin errors++; $display("FAIL vs_low_count got=%0d exp=%0d", n_vl, cfg_b.vs * h_total(cfg_b)); end
  endtask

  task automatic test_random_reset();
    logic [41:0] ea, eb;
    int hold = 0;
    for (int i = 0; i < 2500; i++) begin
      if (hold == 0 && $urandom_range(0, 299) == 0) hold = int'($urandom_range(1, 4));
      rst = (hold > 0);
      if (hold > 0) hold--;
      tick();
      ea = model_out(cfg_a, cnt, lm_a);
      eb = model_out(cfg_b, cnt, lm_b);
      checks++;
      if (obs_a !== ea) begin errors++; $display("FAIL rand_a cnt=%0d got=%h exp=%h", cnt, obs_a, ea); end
      checks++;
      if (obs_b !== eb) begin errors++; $display("FAIL rand_b cnt=%0d got=%h exp=%h", cnt, obs_b, eb); end
    end
    rst = 1'b0;
  endtask

  initial begin
    cfg_a = '{A_HV, A_HF, A_HS, A_HB, A_VV, A_VF, A_VS, A_VB, 1'b1, 1'b1, 2};
    cfg_b = '{B_HV, B_HF, B_HS, B_HB, B_VV, B_VF, B_VS, B_VB, 1'b0, 1'b0, 0};
    test_reset();
    test_sweep();
    test_mid_reset();
    test_polarity();
    test_random_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
